// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: takes a WIDTH-bit word over valid/ready and emits it
// one bit per clock with registered ser_valid/sof/eof framing flags.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
  localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             sof_q;
  logic             eof_q;
  logic             busy_q;

  logic             last_bit;
  logic             accept;
  logic             din_head_d;
  logic             shift_head_d;
  logic [WIDTH-1:0] din_rest_d;
  logic [WIDTH-1:0] shift_rest_d;

  // The register always holds the bits not yet sent; the outgoing bit is
  // peeled off into ser_out_q on the same edge.
  always_comb begin
    if (LSB_FIRST != 0) begin
      din_head_d   = din[0];
      shift_head_d = shift_q[0];
      din_rest_d   = din >> 1;
      shift_rest_d = shift_q >> 1;
    end else begin
      din_head_d   = din[WIDTH-1];
      shift_head_d = shift_q[WIDTH-1];
      din_rest_d   = din << 1;
      shift_rest_d = shift_q << 1;
    end
  end

  assign last_bit  = (state_q == S_SHIFT) && (bit_cnt_q == LAST_BIT);
  assign din_ready = (state_q == S_IDLE) || ((GAP == 0) && last_bit);
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      // Accept is only possible from IDLE or on the last bit with no gap.
      state_q     <= S_SHIFT;
      shift_q     <= din_rest_d;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out_q   <= din_head_d;
      ser_valid_q <= 1'b1;
      sof_q       <= 1'b1;
      eof_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (!last_bit) begin
            shift_q     <= shift_rest_d;
            bit_cnt_q   <= bit_cnt_q + 1'b1;
            ser_out_q   <= shift_head_d;
            ser_valid_q <= 1'b1;
            sof_q       <= 1'b0;
            eof_q       <= (bit_cnt_q == PRE_LAST);
            busy_q      <= 1'b1;
          end else begin
            state_q     <= (GAP > 0) ? S_GAP : S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= (GAP > 0);
          end
        end
        S_GAP: begin
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          sof_q       <= 1'b0;
          eof_q       <= 1'b0;
          if (gap_cnt_q == GAP_LAST) begin
            state_q   <= S_IDLE;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          // IDLE without a word, and any unused encoding, settle here.
          state_q     <= S_IDLE;
          shift_q     <= '0;
          bit_cnt_q   <= '0;
          gap_cnt_q   <= '0;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          sof_q       <= 1'b0;
          eof_q       <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first/no-gap and LSB-first/gap-2 instances,
// scoreboard of expected bits checked whenever ser_valid is high.
module tb_bit_serializer;

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din_a = '0, din_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       rdy_a, out_a, sv_a, sof_a, eof_a, busy_a;
  logic       rdy_b, out_b, sv_b, sof_b, eof_b, busy_b;

  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   run_a = 0, max_run_a = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(rdy_a),
    .ser_out(out_a), .ser_valid(sv_a), .sof(sof_a), .eof(eof_a), .busy(busy_a)
  );

  bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(2)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(rdy_b),
    .ser_out(out_b), .ser_valid(sv_b), .sof(sof_b), .eof(eof_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input bit lsb, input logic [7:0] w, inout exp_t q[$]);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b = lsb ? w[i] : w[7-i];
      e.s = (i == 0);
      e.e = (i == 7);
      q.push_back(e);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge with the number
  // of edges waited before din_ready allowed the accept.
  task automatic send_a(input logic [7:0] w, output int waited);
    waited = 0;
    din_a = w;
    valid_a = 1'b1;
    while (!rdy_a && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("send_a_ready", {31'd0, rdy_a}, 32'd1);
    if (rdy_a) push_word(1'b0, w, q_a);
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] w);
    int n = 0;
    din_b = w;
    valid_b = 1'b1;
    while (!rdy_b && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_b_ready", {31'd0, rdy_b}, 32'd1);
    if (rdy_b) push_word(1'b1, w, q_b);
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard monitors sample on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sv_a) begin
      run_a++;
      if (run_a > max_run_a) max_run_a = run_a;
      if (q_a.size() == 0) chk("a_unexpected_bit", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        chk("a_ser_out", {31'd0, out_a}, {31'd0, e.b});
        chk("a_sof", {31'd0, sof_a}, {31'd0, e.s});
        chk("a_eof", {31'd0, eof_a}, {31'd0, e.e});
      end
    end else begin
      run_a = 0;
      chk("a_idle_flags", {29'd0, out_a, sof_a, eof_a}, 32'd0);
    end
    if (sv_b) begin
      if (q_b.size() == 0) chk("b_unexpected_bit", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_ser_out", {31'd0, out_b}, {31'd0, e.b});
        chk("b_sof", {31'd0, sof_b}, {31'd0, e.s});
        chk("b_eof", {31'd0, eof_b}, {31'd0, e.e});
      end
    end else begin
      chk("b_idle_flags", {29'd0, out_b, sof_b, eof_b}, 32'd0);
    end
  end

  initial begin
    int w;
    // Reset and idle
    #2;
    chk("rst_outputs_a", {27'd0, out_a, sv_a, sof_a, eof_a, busy_a}, 32'd0);
    chk("rst_ready_a", {31'd0, rdy_a}, 32'd1);
    chk("rst_outputs_b", {27'd0, out_b, sv_b, sof_b, eof_b, busy_b}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_outputs_a", {27'd0, out_a, sv_a, sof_a, eof_a, busy_a}, 32'd0);
      chk("idle_ready_a", {31'd0, rdy_a}, 32'd1);
      step(1);
    end

    // Single MSB-first word, then back to idle
    send_a(8'b1011_0010, w);
    chk("single_accept_wait", w, 32'd0);
    step(8);
    chk("single_done_busy", {31'd0, busy_a}, 32'd0);
    chk("single_done_ready", {31'd0, rdy_a}, 32'd1);
    chk("single_drained", q_a.size(), 32'd0);

    // Back-to-back with valid held high: 16 bits, no bubble
    max_run_a = 0;
    send_a(8'hF0, w);
    valid_a = 1'b1;
    send_a(8'h0F, w);
    chk("b2b_accept_at_bit8", w, 32'd7);
    step(9);
    chk("b2b_run_length", max_run_a, 32'd16);
    chk("b2b_drained", q_a.size(), 32'd0);

    // Stall: second word offered while busy, accepted only at the bit-8 edge
    send_a(8'h3C, w);
    send_a(8'h96, w);
    chk("stall_accept_at_bit8", w, 32'd7);
    step(9);
    chk("stall_drained", q_a.size(), 32'd0);

    // LSB-first with a 2-cycle gap
    send_b(8'hA5);
    step(7);
    chk("gap_last_bit_valid", {31'd0, sv_b}, 32'd1);
    for (int g = 0; g < 2; g++) begin
      step(1);
      chk("gap_valid", {31'd0, sv_b}, 32'd0);
      chk("gap_busy", {31'd0, busy_b}, 32'd1);
      chk("gap_ready", {31'd0, rdy_b}, 32'd0);
    end
    step(1);
    chk("gap_end_ready", {31'd0, rdy_b}, 32'd1);
    chk("gap_end_busy", {31'd0, busy_b}, 32'd0);
    chk("gap_drained", q_b.size(), 32'd0);

    // Asynchronous reset in the middle of a word
    send_a(8'hC3, w);
    step(1);
    chk("midrst_pre_out", {31'd0, out_a}, 32'd1);
    chk("midrst_pre_busy", {31'd0, busy_a}, 32'd1);
    #1;
    rst = 1'b1;
    q_a.delete();
    #1;
    chk("midrst_outputs", {27'd0, out_a, sv_a, sof_a, eof_a, busy_a}, 32'd0);
    chk("midrst_ready", {31'd0, rdy_a}, 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {31'd0, sv_a}, 32'd0);
    send_a(8'h81, w);
    step(8);
    chk("post_rst_drained", q_a.size(), 32'd0);
    chk("post_rst_busy", {31'd0, busy_a}, 32'd0);

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
